// File: rtl/shot_possession_ctrl.sv
// Game-side controller for the shot clock: drives the shoot level, scores made shots,
// counts shot-clock violations per team and ends the game after MAX_POSS possessions.
module shot_possession_ctrl #(
    parameter int GAP_CYC  = 3,
    parameter int POINTS   = 2,
    parameter int MAX_POSS = 8,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               score_btn,
    input  logic               miss_btn,
    input  logic [3:0]         count,
    input  logic               buzz,
    output logic               shoot,
    output logic               possession,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [3:0]         viol_a,
    output logic [3:0]         viol_b,
    output logic [3:0]         last_count,
    output logic [7:0]         poss_num,
    output logic               done
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [7:0] POSS_LAST = 8'(MAX_POSS);
    // Points are clamped to the score range so the sum below can never wrap past the carry bit.
    localparam logic [SCORE_W:0] PTS_W =
        (SCORE_W + 1)'((POINTS >= (1 << SCORE_W)) ? ((1 << SCORE_W) - 1) : POINTS);

    typedef enum logic [1:0] {IDLE, GAP, LIVE, DONE} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               start_q, score_q, miss_q, buzz_q;
    logic               shoot_q, shoot_d, possession_q, possession_d, done_q, done_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
    logic [3:0]         viol_a_q, viol_a_d, viol_b_q, viol_b_d;
    logic [3:0]         last_count_q, last_count_d;
    logic [7:0]         poss_num_q, poss_num_d;
    logic               start_edge, score_edge, miss_edge, buzz_edge, end_poss;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + PTS_W;
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign start_edge = start & ~start_q;
    assign score_edge = score_btn & ~score_q;
    assign miss_edge  = miss_btn & ~miss_q;
    assign buzz_edge  = buzz & ~buzz_q;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        possession_d = possession_q;
        score_a_d    = score_a_q;
        score_b_d    = score_b_q;
        viol_a_d     = viol_a_q;
        viol_b_d     = viol_b_q;
        last_count_d = last_count_q;
        poss_num_d   = poss_num_q;
        end_poss     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d      = GAP;
                    gap_d        = '0;
                    possession_d = 1'b0;
                    score_a_d    = '0;
                    score_b_d    = '0;
                    viol_a_d     = '0;
                    viol_b_d     = '0;
                    last_count_d = '0;
                    poss_num_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = LIVE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            LIVE: begin
                // Only the highest-priority edge acts; the rest are dropped, not queued.
                if (score_edge) begin
                    if (possession_q) score_b_d = sat_add(score_b_q);
                    else              score_a_d = sat_add(score_a_q);
                    last_count_d = count;
                    end_poss     = 1'b1;
                end else if (buzz_edge) begin
                    if (possession_q) viol_b_d = sat_inc(viol_b_q);
                    else              viol_a_d = sat_inc(viol_a_q);
                    end_poss = 1'b1;
                end else if (miss_edge) begin
                    end_poss = 1'b1;
                end
                if (end_poss) begin
                    possession_d = ~possession_q;
                    poss_num_d   = poss_num_q + 8'd1;
                    state_d      = (poss_num_d == POSS_LAST) ? DONE : GAP;
                end
            end
            default: state_d = IDLE;
        endcase

        shoot_d = (state_d == LIVE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            start_q      <= 1'b0;
            score_q      <= 1'b0;
            miss_q       <= 1'b0;
            buzz_q       <= 1'b0;
            shoot_q      <= 1'b0;
            possession_q <= 1'b0;
            done_q       <= 1'b0;
            score_a_q    <= '0;
            score_b_q    <= '0;
            viol_a_q     <= '0;
            viol_b_q     <= '0;
            last_count_q <= '0;
            poss_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            start_q      <= start;
            score_q      <= score_btn;
            miss_q       <= miss_btn;
            buzz_q       <= buzz;
            shoot_q      <= shoot_d;
            possession_q <= possession_d;
            done_q       <= done_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            viol_a_q     <= viol_a_d;
            viol_b_q     <= viol_b_d;
            last_count_q <= last_count_d;
            poss_num_q   <= poss_num_d;
        end
    end

    assign shoot      = shoot_q;
    assign possession = possession_q;
    assign score_a    = score_a_q;
    assign score_b    = score_b_q;
    assign viol_a     = viol_a_q;
    assign viol_b     = viol_b_q;
    assign last_count = last_count_q;
    assign poss_num   = poss_num_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shot_possession_ctrl.sv
// Directed bench for shot_possession_ctrl: a default instance plus a 2-bit-score
// instance driven by the same inputs to exercise score saturation.
module tb_shot_possession_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, score_btn, miss_btn, buzz;
    logic [3:0] count;

    logic       shoot, possession, done;
    logic [7:0] score_a, score_b, poss_num;
    logic [3:0] viol_a, viol_b, last_count;

    logic       s_shoot, s_possession, s_done;
    logic [1:0] s_score_a, s_score_b;
    logic [7:0] s_poss_num;
    logic [3:0] s_viol_a, s_viol_b, s_last_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shot_possession_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .score_btn(score_btn), .miss_btn(miss_btn),
        .count(count), .buzz(buzz), .shoot(shoot), .possession(possession),
        .score_a(score_a), .score_b(score_b), .viol_a(viol_a), .viol_b(viol_b),
        .last_count(last_count), .poss_num(poss_num), .done(done)
    );

    shot_possession_ctrl #(.SCORE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .score_btn(score_btn), .miss_btn(miss_btn),
        .count(count), .buzz(buzz), .shoot(s_shoot), .possession(s_possession),
        .score_a(s_score_a), .score_b(s_score_b), .viol_a(s_viol_a), .viol_b(s_viol_b),
        .last_count(s_last_count), .poss_num(s_poss_num), .done(s_done)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; score_btn = 1'b0; miss_btn = 1'b0; buzz = 1'b0;
        count = 4'd0;
        applyStimulus(2);
        checkOutput("rst_shoot", shoot, 0);
        checkOutput("rst_poss", possession, 0);
        checkOutput("rst_score_a", score_a, 0);
        checkOutput("rst_score_b", score_b, 0);
        checkOutput("rst_viol_a", viol_a, 0);
        checkOutput("rst_viol_b", viol_b, 0);
        checkOutput("rst_last", last_count, 0);
        checkOutput("rst_poss_num", poss_num, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sat_all", {s_shoot, s_possession, s_done, s_score_a, s_score_b,
                                    s_viol_a, s_viol_b, s_last_count, s_poss_num}, 0);
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("idle_shoot", shoot, 0);

        // Start: shoot low for 3 cycles, then high.
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("gap1_shoot", shoot, 0);
        applyStimulus(1);
        checkOutput("gap2_shoot", shoot, 0);
        applyStimulus(1);
        checkOutput("gap3_shoot", shoot, 0);
        applyStimulus(1);
        checkOutput("live_shoot", shoot, 1);
        checkOutput("live_poss", possession, 0);

        // Team A makes a shot at count 7.
        count = 4'd7; score_btn = 1'b1;
        applyStimulus(1);
        score_btn = 1'b0;
        checkOutput("shot_score_a", score_a, 2);
        checkOutput("shot_last", last_count, 7);
        checkOutput("shot_poss", possession, 1);
        checkOutput("shot_poss_num", poss_num, 1);
        checkOutput("shot_shoot", shoot, 0);
        applyStimulus(2);
        checkOutput("shot_gap_shoot", shoot, 0);
        applyStimulus(1);
        checkOutput("shot_live_shoot", shoot, 1);

        // Team B shot-clock violation; buzz held high through the gap must not re-fire.
        buzz = 1'b1;
        applyStimulus(1);
        checkOutput("viol_b", viol_b, 1);
        checkOutput("viol_score_b", score_b, 0);
        checkOutput("viol_poss", possession, 0);
        checkOutput("viol_poss_num", poss_num, 2);
        applyStimulus(3);
        checkOutput("viol_live_shoot", shoot, 1);
        applyStimulus(1);
        checkOutput("buzz_hold_viol_a", viol_a, 0);
        checkOutput("buzz_hold_poss_num", poss_num, 2);
        checkOutput("buzz_hold_shoot", shoot, 1);
        buzz = 1'b0;
        applyStimulus(1);

        // Score, buzz and miss in one cycle: only the score applies.
        count = 4'd3; score_btn = 1'b1; buzz = 1'b1; miss_btn = 1'b1;
        applyStimulus(1);
        score_btn = 1'b0; buzz = 1'b0; miss_btn = 1'b0;
        checkOutput("simul_score_a", score_a, 4);
        checkOutput("simul_viol_a", viol_a, 0);
        checkOutput("simul_viol_b", viol_b, 1);
        checkOutput("simul_poss_num", poss_num, 3);
        checkOutput("simul_last", last_count, 3);
        checkOutput("sat_score_a", s_score_a, 3);
        applyStimulus(3);
        checkOutput("simul_live_shoot", shoot, 1);

        // Five misses finish the eight-possession game.
        for (int i = 0; i < 5; i++) begin
            miss_btn = 1'b1;
            applyStimulus(1);
            miss_btn = 1'b0;
            checkOutput("miss_poss_num", poss_num, 32'(4 + i));
            if (i < 4) begin
                checkOutput("miss_done_low", done, 0);
                applyStimulus(3);
                checkOutput("miss_live_shoot", shoot, 1);
            end
        end
        checkOutput("end_done", done, 1);
        checkOutput("end_shoot", shoot, 0);
        checkOutput("end_poss", possession, 0);

        // Buttons in DONE change nothing.
        score_btn = 1'b1;
        applyStimulus(1);
        score_btn = 1'b0;
        checkOutput("done_score_a", score_a, 4);
        checkOutput("done_score_b", score_b, 0);
        checkOutput("done_poss_num", poss_num, 8);
        checkOutput("done_hold", done, 1);

        // Restart from DONE.
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart_done", done, 0);
        checkOutput("restart_score_a", score_a, 0);
        checkOutput("restart_viol_b", viol_b, 0);
        checkOutput("restart_last", last_count, 0);
        checkOutput("restart_poss_num", poss_num, 0);
        checkOutput("restart_shoot", shoot, 0);
        applyStimulus(3);
        checkOutput("restart_live", shoot, 1);

        // Score once, then reset mid-LIVE with a coincident score edge.
        count = 4'd5; score_btn = 1'b1;
        applyStimulus(1);
        score_btn = 1'b0;
        checkOutput("pre_rst_score_a", score_a, 2);
        applyStimulus(3);
        checkOutput("pre_rst_live", shoot, 1);
        rst = 1'b1; score_btn = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_shoot", shoot, 0);
        checkOutput("mid_rst_score_a", score_a, 0);
        checkOutput("mid_rst_score_b", score_b, 0);
        checkOutput("mid_rst_poss", possession, 0);
        checkOutput("mid_rst_last", last_count, 0);
        checkOutput("mid_rst_poss_num", poss_num, 0);
        rst = 1'b0;
        applyStimulus(4);
        checkOutput("post_rst_idle_shoot", shoot, 0);
        checkOutput("post_rst_idle_score_b", score_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
